// File: rtl/bsr_chain.sv
// Boundary-scan register chain: input cells, output cells and one output-enable cell.
// Shift/update registers clocked by tck; pad/core muxing is combinational on bsr_mode.
module bsr_chain #(
  parameter int NUM_IN  = 4,
  parameter int NUM_OUT = 4
) (
  input  logic               tck,
  input  logic               trst,
  input  logic               bsr_tdi,
  input  logic               bsr_clk,
  input  logic               bsr_shift,
  input  logic               bsr_update,
  input  logic               bsr_mode,
  output logic               bsr_tdo,
  input  logic [NUM_IN-1:0]  pad_in,
  output logic [NUM_IN-1:0]  core_in,
  input  logic [NUM_OUT-1:0] core_out,
  input  logic               core_oe,
  output logic [NUM_OUT-1:0] pad_out,
  output logic               pad_oe
);

  localparam int L = NUM_IN + NUM_OUT + 1;

  logic [L-1:0] sr;
  logic [L-1:0] upd;

  // Update samples sr before this edge, so it is unaffected by a simultaneous shift/capture.
  always_ff @(posedge tck) begin
    if (trst) begin
      sr  <= '0;
      upd <= '0;
    end else begin
      if (bsr_clk) begin
        if (bsr_shift) sr <= {bsr_tdi, sr[L-1:1]};
        else           sr <= {core_oe, core_out, pad_in};
      end
      if (bsr_update) upd <= sr;
    end
  end

  assign bsr_tdo = sr[0];

  // In test mode the pads are forced safe while reset is held, before upd has cleared.
  always_comb begin
    core_in = pad_in;
    pad_out = core_out;
    pad_oe  = core_oe;
    if (bsr_mode) begin
      if (trst) begin
        core_in = '0;
        pad_out = '0;
        pad_oe  = 1'b0;
      end else begin
        core_in = upd[NUM_IN-1:0];
        pad_out = upd[NUM_IN+NUM_OUT-1:NUM_IN];
        pad_oe  = upd[L-1];
      end
    end
  end

endmodule

// File: tb/tb_bsr_chain.sv
// Self-checking bench for bsr_chain: a directed vector table, hand-written corner
// sequences and a randomized run against a queue-based reference model.
module tb_bsr_chain;

  localparam int NI = 4;
  localparam int NO = 4;
  localparam int L  = NI + NO + 1;

  logic          tck = 1'b0;
  logic          trst, bsr_tdi, bsr_clk, bsr_shift, bsr_update, bsr_mode;
  logic          bsr_tdo;
  logic [NI-1:0] pad_in, core_in;
  logic [NO-1:0] core_out, pad_out;
  logic          core_oe, pad_oe;

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: scan_q[0] is the cell nearest bsr_tdo.
  bit scan_q[$];
  bit upd_m[L];

  bsr_chain #(.NUM_IN(NI), .NUM_OUT(NO)) dut (
    .tck(tck), .trst(trst), .bsr_tdi(bsr_tdi), .bsr_clk(bsr_clk),
    .bsr_shift(bsr_shift), .bsr_update(bsr_update), .bsr_mode(bsr_mode),
    .bsr_tdo(bsr_tdo), .pad_in(pad_in), .core_in(core_in),
    .core_out(core_out), .core_oe(core_oe), .pad_out(pad_out), .pad_oe(pad_oe)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic          rst, clk, shift, update, mode, tdi;
    logic [NI-1:0] pin;
    logic [NO-1:0] cout;
    logic          coe;
    logic          exp_tdo;
    logic [NI-1:0] exp_core_in;
    logic [NO-1:0] exp_pad_out;
    logic          exp_pad_oe;
  } vec_t;

  vec_t tbl[11];

  function automatic vec_t mkVec(input logic rst, clk, shift, tdi, exp_tdo);
    vec_t v;
    v.rst = rst; v.clk = clk; v.shift = shift; v.update = 1'b0; v.mode = 1'b0;
    v.tdi = tdi; v.pin = 4'hA; v.cout = 4'h5; v.coe = 1'b1;
    v.exp_tdo = exp_tdo; v.exp_core_in = 4'hA; v.exp_pad_out = 4'h5; v.exp_pad_oe = 1'b1;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic modelStep();
    bit old_q[L];
    for (int i = 0; i < L; i++) old_q[i] = scan_q[i];
    if (trst) begin
      scan_q = {};
      for (int i = 0; i < L; i++) begin
        scan_q.push_back(1'b0);
        upd_m[i] = 1'b0;
      end
    end else begin
      if (bsr_clk) begin
        if (bsr_shift) begin
          void'(scan_q.pop_front());
          scan_q.push_back(bsr_tdi);
        end else begin
          scan_q = {};
          for (int i = 0; i < NI; i++) scan_q.push_back(pad_in[i]);
          for (int i = 0; i < NO; i++) scan_q.push_back(core_out[i]);
          scan_q.push_back(core_oe);
        end
      end
      if (bsr_update) for (int i = 0; i < L; i++) upd_m[i] = old_q[i];
    end
  endtask

  task automatic checkModel(input string tag);
    logic [NI-1:0] e_ci;
    logic [NO-1:0] e_po;
    logic          e_oe;
    e_ci = pad_in; e_po = core_out; e_oe = core_oe;
    if (bsr_mode) begin
      for (int i = 0; i < NI; i++) e_ci[i] = trst ? 1'b0 : upd_m[i];
      for (int i = 0; i < NO; i++) e_po[i] = trst ? 1'b0 : upd_m[NI+i];
      e_oe = trst ? 1'b0 : upd_m[L-1];
    end
    checkOutput({tag, "_tdo"}, bsr_tdo, scan_q[0]);
    checkOutput({tag, "_core_in"}, core_in, e_ci);
    checkOutput({tag, "_pad_out"}, pad_out, e_po);
    checkOutput({tag, "_pad_oe"}, pad_oe, e_oe);
  endtask

  // Drive one cycle of inputs, advance the model, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic rst, clk, shift, update, mode, tdi,
                               input logic [NI-1:0] pin, input logic [NO-1:0] cout,
                               input logic coe);
    trst = rst; bsr_clk = clk; bsr_shift = shift; bsr_update = update;
    bsr_mode = mode; bsr_tdi = tdi; pad_in = pin; core_out = cout; core_oe = coe;
    modelStep();
    @(posedge tck);
    #1;
  endtask

  task automatic checkPads(input string tag, input logic [NI-1:0] ci,
                           input logic [NO-1:0] po, input logic oe);
    checkOutput({tag, "_core_in"}, core_in, ci);
    checkOutput({tag, "_pad_out"}, pad_out, po);
    checkOutput({tag, "_pad_oe"}, pad_oe, oe);
  endtask

  initial begin
    logic [L-1:0]  pattern;
    logic [NI-1:0] rnd_pin;

    for (int i = 0; i < L; i++) scan_q.push_back(1'b0);
    trst = 1'b1; bsr_clk = 1'b0; bsr_shift = 1'b0; bsr_update = 1'b0;
    bsr_mode = 1'b0; bsr_tdi = 1'b0; pad_in = '0; core_out = '0; core_oe = 1'b0;
    #1;

    // Capture pad_in=A, core_out=5, oe=1, then scan out 9 bits.
    tbl[0] = mkVec(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tbl[1] = mkVec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tbl[2] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[3] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[4] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[5] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[6] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[7] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[8] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    tbl[9] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
    tbl[10] = mkVec(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].rst, tbl[i].clk, tbl[i].shift, tbl[i].update, tbl[i].mode,
                    tbl[i].tdi, tbl[i].pin, tbl[i].cout, tbl[i].coe);
      checkOutput($sformatf("vec%0d_tdo", i), bsr_tdo, tbl[i].exp_tdo);
      checkPads($sformatf("vec%0d", i), tbl[i].exp_core_in, tbl[i].exp_pad_out, tbl[i].exp_pad_oe);
    end

    // EXTEST preload of 1_0011_0000, then update into test mode.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h6, 4'hC, 1'b0);
    pattern = 9'b1_0011_0000;
    for (int i = 0; i < L; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, pattern[i], 4'h6, 4'hC, 1'b0);
    checkOutput("preload_sr", dut.sr, 9'h130);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h6, 4'hC, 1'b0);
    checkPads("extest", 4'h0, 4'h3, 1'b1);

    // Mode toggle takes effect without a clock edge and leaves state alone.
    bsr_mode = 1'b0; #1;
    checkPads("toggle_m0", 4'h6, 4'hC, 1'b0);
    bsr_mode = 1'b1; #1;
    checkPads("toggle_m1", 4'h0, 4'h3, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 4'hC, 1'b0);
    checkOutput("toggle_sr", dut.sr, 9'h130);
    checkOutput("toggle_upd", dut.upd, 9'h130);

    // Simultaneous update and shift: upd takes the pre-shift contents.
    for (int i = 0; i < L; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'h6, 4'hC, 1'b0);
    checkOutput("ones_sr", dut.sr, 9'h1FF);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'h6, 4'hC, 1'b0);
    checkOutput("simul_upd", dut.upd, 9'h1FF);
    checkOutput("simul_sr", dut.sr, 9'h0FF);
    checkPads("simul", 4'hF, 4'hF, 1'b1);

    // Reset after 4 of 9 shifts in test mode.
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, i[0], 4'h6, 4'hC, 1'b0);
    trst = 1'b1; #1;
    checkPads("rst_comb", 4'h0, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h6, 4'hC, 1'b1);
    checkOutput("rst_tdo", bsr_tdo, 1'b0);
    checkPads("rst_edge", 4'h0, 4'h0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'h6, 4'hC, 1'b1);
    checkPads("post_rst", 4'h0, 4'h0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h9, 4'h7, 1'b1);
    checkPads("rst_m0", 4'h9, 4'h7, 1'b1);
    rnd_pin = NI'($urandom);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, rnd_pin, 4'h7, 1'b1);
    checkOutput("recap_bit0", bsr_tdo, rnd_pin[0]);
    for (int i = 1; i < NI; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rnd_pin, 4'h7, 1'b1);
      checkOutput($sformatf("recap_bit%0d", i), bsr_tdo, rnd_pin[i]);
    end

    // Hold: bsr_clk low while bsr_shift toggles.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'hB, 4'hE, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'h2, 4'h1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b0, i[0], 1'b0, 1'b1, i[1], NI'($urandom), NO'($urandom), 1'b0);
      checkOutput($sformatf("hold%0d_tdo", i), bsr_tdo, 1'b1);
      checkPads($sformatf("hold%0d", i), 4'hB, 4'hE, 1'b1);
    end

    // Randomized run against the reference model.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 31) == 0, 1'($urandom), 1'($urandom),
                    $urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom),
                    NI'($urandom), NO'($urandom), 1'($urandom));
      checkModel($sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/bsr_chain.md
BSR_CHAIN -- requirements
Module: bsr_chain

Interface
REQ-001 Parameter NUM_IN, default 4: number of input boundary cells (pad -> core).
REQ-002 Parameter NUM_OUT, default 4: number of output boundary cells (core -> pad).
REQ-003 Derived constant L = NUM_IN + NUM_OUT + 1: chain length, including one output-enable control cell.
REQ-004 tck  input  1  sole clock; all state changes on its rising edge.
REQ-005 trst  input  1  synchronous, active-high reset.
REQ-006 bsr_tdi  input  1  serial scan data from the TAP controller.
REQ-007 bsr_clk  input  1  ClockDR strobe, used as a clock enable: capture or shift this cycle.
REQ-008 bsr_shift  input  1  1 = shift when bsr_clk is high; 0 = capture when bsr_clk is high.
REQ-009 bsr_update  input  1  UpdateDR strobe: load the update register from the shift register.
REQ-010 bsr_mode  input  1  0 = functional pass-through; 1 = test (EXTEST/INTEST) drive from the update register.
REQ-011 bsr_tdo  output  1  serial scan data returned to the TAP controller.
REQ-012 pad_in  input  NUM_IN  pad-side input pins.
REQ-013 core_in  output  NUM_IN  core-side view of the input pins.
REQ-014 core_out  input  NUM_OUT  core-driven output values.
REQ-015 core_oe  input  1  core-driven output enable.
REQ-016 pad_out  output  NUM_OUT  values driven to the output pads.
REQ-017 pad_oe  output  1  output pad enable.

Function
REQ-018 Internal state: shift register sr[L-1:0] and update register upd[L-1:0].
REQ-019 Bit map for both sr and upd:
- [NUM_IN-1:0] = input cells.
- [NUM_IN+NUM_OUT-1:NUM_IN] = output cells.
- [L-1] = OE cell.
REQ-020 Shift: when bsr_clk=1 and bsr_shift=1, sr <= {bsr_tdi, sr[L-1:1]}, i.e. data enters at the OE cell and exits at input cell 0.
REQ-021 bsr_tdo equals sr[0] combinationally, so the first bit shifted out is the value held before the first shift.
REQ-022 Capture: when bsr_clk=1 and bsr_shift=0, load input cells <= pad_in, output cells <= core_out, OE cell <= core_oe.
REQ-023 Hold: when bsr_clk=0, sr holds its value regardless of bsr_shift.
REQ-024 Update: when bsr_update=1, upd <= sr as it was before this edge; this is independent of any simultaneous capture or shift.
REQ-025 Hold: when bsr_update=0, upd holds its value.
REQ-026 Mode 0 (combinational pass-through):
- core_in = pad_in.
- pad_out = core_out.
- pad_oe = core_oe.
REQ-027 Mode 1 (combinational from upd):
- core_in = upd input cells.
- pad_out = upd output cells.
- pad_oe = upd OE cell.
REQ-028 Latency:
- Capture value is visible on bsr_tdo one cycle after the capture strobe.
- Update value is visible on the pads one cycle after the update strobe, when bsr_mode=1.
REQ-029 Chain integrity: L consecutive shifts return the original L-bit contents on bsr_tdo, LSB first.
REQ-030 Mode switching: a change of bsr_mode takes effect in the same cycle and never alters sr or upd.

Reset
REQ-031 trst=1 at a rising tck sets sr=0 and upd=0.
REQ-032 trst overrides shift, capture and update in the same cycle.
REQ-033 While trst=1 and bsr_mode=1: pad_oe=0, pad_out=0, core_in=0.
REQ-034 In mode 0, outputs remain pass-through during reset.
REQ-035 Reset asserted mid-shift discards the partial scan; the next capture starts from a clean state.

Verification
REQ-036 Capture/scan-out: pad_in=4'hA, core_out=4'h5, core_oe=1; one capture, then 9 shifts with bsr_tdi=0 -> bsr_tdo sequence 0,1,0,1,1,0,1,0,1.
REQ-037 EXTEST preload: shift in 9 bits so that sr = 9'b1_0011_0000, pulse bsr_update, bsr_mode=1 -> pad_out=4'h3 and pad_oe=1 on the next cycle; core_in=4'h0.
REQ-038 Simultaneous update and shift: sr=9'h1FF, bsr_clk=bsr_shift=bsr_update=1 with bsr_tdi=0 -> upd=9'h1FF and sr=9'h0FF after the edge.
REQ-039 Mode toggle: with upd holding the 9'b1_0011_0000 pattern, toggle bsr_mode 1->0->1 -> pads follow core_out/core_oe when bsr_mode=0 and restore to 4'h3/1 when bsr_mode=1; sr and upd unchanged.
REQ-040 Reset mid-operation: trst after 4 of 9 shifts in test mode -> pad_oe=0, pad_out=0, bsr_tdo=0 next cycle; a following capture re-reads pad_in correctly.
REQ-041 Hold: bsr_clk=0 with bsr_shift toggling for 10 cycles -> bsr_tdo and pads stable.
